mux_rr_arbiter: RTL and testbench

- Round-robin arbiter/scheduler that shares one N-to-1 data mux (one output channel) between N requesters.
- Each requester presents data with a valid/ready handshake.
- The arbiter selects one requester, steers its data through the mux into a single output register, and holds it until the downstream consumer accepts it.
- Sits between the requesters and any single shared consumer in the datapath.

---
 rtl/mux_rr_arbiter.sv | 68 ++++++
 tb/tb_mux_rr_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered N-to-1 output channel between N valid/ready requesters.
// One-cycle latency from handshake to out_data; a stalled output withholds every req_ready.
module mux_rr_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] idx;
  logic           found;
  logic           can_accept;
  logic           xfer;

  assign can_accept = !out_valid || out_ready;

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Gated by rst_n so no handshake can complete while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && found) begin
      req_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= req_data[gnt*W +: W];
      out_id    <= gnt;
      rr_ptr    <= gnt + IDW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios then random traffic against a reference model.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: what the output register should hold and who is next in line.
  logic       m_vld;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;

  mux_rr_arbiter #(.N(N), .W(W), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = 8'h00;
    m_id   = 0;
    m_ptr  = 0;
  endtask

  // One cycle: check registered outputs, drive inputs, check the grant, advance the model.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int g;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("out_id", {30'd0, out_id}, m_id);
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    #1;
    g = -1;
    if (!m_vld || ordy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    chk("req_ready", {28'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      m_vld  = 1'b1;
      m_data = d[g*8 +: 8];
      m_id   = g;
      m_ptr  = (g + 1) % N;
    end else if (m_vld && ordy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, {31'd0, m_vld});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_id", {30'd0, out_id}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    model_reset();
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rr_d;
    rr_d      = 32'h1312_1110;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    chk("init_valid", {31'd0, out_valid}, 32'd0);
    chk("init_data", {24'd0, out_data}, 32'd0);
    chk("init_id", {30'd0, out_id}, 32'd0);
    chk("init_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2, then skip-and-wrap from pointer 3.
    step(4'b0100, 32'h00A5_0000, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    chk("single_id", {30'd0, out_id}, 32'd2);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    step(4'b0011, rr_d, 1'b1);
    step(4'b0011, rr_d, 1'b1);
    chk("wrap_id0", {30'd0, out_id}, 32'd0);
    step(4'b0000, rr_d, 1'b1);
    chk("wrap_id1", {30'd0, out_id}, 32'd1);
    step(4'b0000, rr_d, 1'b1);
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Reset while a word is held.
    step(4'b1111, rr_d, 1'b1);
    reset_mid_cycle();

    // Full round-robin, then two more grants to hold id 1.
    repeat (10) step(4'b1111, rr_d, 1'b1);
    repeat (3) step(4'b1111, rr_d, 1'b0);
    chk("stall_data", {24'd0, out_data}, 32'h11);
    step(4'b1111, rr_d, 1'b1);
    step(4'b0000, rr_d, 1'b0);
    chk("after_stall", {24'd0, out_data}, 32'h12);

    // Requester 1 pulses while stalled and must not be served.
    step(4'b0010, rr_d, 1'b0);
    step(4'b0000, rr_d, 1'b0);
    step(4'b0000, rr_d, 1'b1);
    step(4'b0010, rr_d, 1'b1);
    step(4'b0000, rr_d, 1'b1);

    repeat (400) begin
      step(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
